// File: rtl/fifo_pkt_reader_if.sv
// Upstream FIFO read port plus downstream out_* word port of fifo_pkt_reader.
// master = the reader itself; slave = the FIFO/downstream environment.
interface fifo_pkt_reader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
);
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
    logic                             fifo_empty;
    logic                             fifo_rd_en;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;

    modport master (
        input  fifo_dout, fifo_empty, out_rdy,
        output fifo_rd_en, out_data, out_ctrl, out_wr
    );

    modport slave (
        output fifo_dout, fifo_empty, out_rdy,
        input  fifo_rd_en, out_data, out_ctrl, out_wr
    );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Drains a registered-read FIFO through a 2-entry skid buffer onto the out_* port
// and tracks packet boundaries (header ctrl!=0, payload ctrl==0, last word ctrl!=0).
module fifo_pkt_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_pkt_reader_if.master    bus,
    input  logic                 drain_en,
    output logic                 eop,
    output logic [CNT_WIDTH-1:0] last_pkt_words,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic                 fmt_err
);
    localparam int W = CTRL_WIDTH + DATA_WIDTH;

    typedef enum logic {HDR, PAYLOAD} state_e;

    logic [W-1:0]         ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]           occ_q, occ_d, occ_net;
    logic                 inflight_q;
    state_e               state_q, state_d;
    logic                 first_q, first_d;
    logic [CNT_WIDTH-1:0] word_ctr_q, word_ctr_d;
    logic [CNT_WIDTH-1:0] last_q, last_d;
    logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
    logic                 fmt_q, fmt_d;

    logic                  pop, push, rd_en, is_last;
    logic [CTRL_WIDTH-1:0] head_ctrl;

    assign head_ctrl = ent0_q[W-1 -: CTRL_WIDTH];
    assign pop       = (occ_q != 2'd0) & bus.out_rdy;
    assign push      = inflight_q;

    // A slot freed by this cycle's transfer counts as free, so reads keep 1 word/clk.
    assign occ_net = occ_q - {1'b0, pop};
    assign rd_en   = drain_en & ~bus.fifo_empty &
                     (({1'b0, occ_net} + {2'b00, inflight_q}) < 3'd2);

    assign is_last = (state_q == PAYLOAD) & (head_ctrl != '0);

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_wr     = pop;
    assign bus.out_data   = ent0_q[DATA_WIDTH-1:0];
    assign bus.out_ctrl   = head_ctrl;
    assign eop            = pop & is_last;
    assign last_pkt_words = last_q;
    assign pkt_cnt        = pkt_q;
    assign fmt_err        = fmt_q;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = bus.fifo_dout;
                else               ent1_d = bus.fifo_dout;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) ent0_d = ent1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = bus.fifo_dout;
                end else begin
                    ent0_d = bus.fifo_dout;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        word_ctr_d = word_ctr_q;
        last_d     = last_q;
        pkt_d      = pkt_q;
        fmt_d      = fmt_q;
        if (pop) begin
            first_d = 1'b0;
            if (first_q && head_ctrl == '0) fmt_d = 1'b1;
            case (state_q)
                HDR:     if (head_ctrl == '0) state_d = PAYLOAD;
                PAYLOAD: if (head_ctrl != '0) state_d = HDR;
                default: state_d = HDR;
            endcase
            if (is_last) begin
                last_d     = word_ctr_q + 1'b1;
                pkt_d      = pkt_q + 1'b1;
                word_ctr_d = '0;
                first_d    = 1'b1;
            end else if (word_ctr_q != '1) begin
                word_ctr_d = word_ctr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            state_q    <= HDR;
            first_q    <= 1'b1;
            word_ctr_q <= '0;
            last_q     <= '0;
            pkt_q      <= '0;
            fmt_q      <= 1'b0;
        end else begin
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            occ_q      <= occ_d;
            inflight_q <= rd_en;
            state_q    <= state_d;
            first_q    <= first_d;
            word_ctr_q <= word_ctr_d;
            last_q     <= last_d;
            pkt_q      <= pkt_d;
            fmt_q      <= fmt_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset) assert (occ_q != 2'd3);
    end
`endif
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader against a registered-read FIFO model.
module tb_fifo_pkt_reader;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          drain_en;
    logic          eop;
    logic [NW-1:0] last_pkt_words;
    logic [NW-1:0] pkt_cnt;
    logic          fmt_err;

    fifo_pkt_reader_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) bus ();

    fifo_pkt_reader #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .CNT_WIDTH(NW)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.master),
        .drain_en       (drain_en),
        .eop            (eop),
        .last_pkt_words (last_pkt_words),
        .pkt_cnt        (pkt_cnt),
        .fmt_err        (fmt_err)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: 1-cycle rd_en to dout latency.
    logic [71:0] mem [0:255];
    int wp = 0;
    int rp = 0;
    assign bus.fifo_empty = (rp == wp);
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_dout <= mem[rp[7:0]];
            rp <= rp + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [71:0] got[$];
    bit          got_eop[$];
    bit          rd_log[$];
    bit          wr_log[$];
    int          n_rd;

    task automatic push(input logic [7:0] c, input logic [63:0] d);
        mem[wp[7:0]] = {c, d};
        wp++;
    endtask

    task automatic clr_mon();
        got.delete(); got_eop.delete(); rd_log.delete(); wr_log.delete(); n_rd = 0;
    endtask

    // Sample the cycle about to be clocked, then advance to the next negedge.
    task automatic tick();
        #1;
        rd_log.push_back(bus.fifo_rd_en);
        wr_log.push_back(bus.out_wr);
        if (bus.fifo_rd_en) n_rd++;
        if (bus.out_wr) begin
            got.push_back({bus.out_ctrl, bus.out_data});
            got_eop.push_back(eop);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; drain_en = 1'b0; bus.out_rdy = 1'b1;
        @(negedge clk);
        clr_mon();
        tick(); tick();
        checks++; if (rd_log[1] !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b exp 0", rd_log[1]); end
        checks++; if (bus.out_wr !== 1'b0) begin errors++; $display("FAIL rst_out_wr got %b exp 0", bus.out_wr); end
        checks++; if (bus.out_data !== 64'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", bus.out_data); end
        checks++; if (bus.out_ctrl !== 8'h0) begin errors++; $display("FAIL rst_out_ctrl got %h exp 0", bus.out_ctrl); end
        checks++; if (eop !== 1'b0) begin errors++; $display("FAIL rst_eop got %b exp 0", eop); end
        checks++; if (last_pkt_words !== 4'd0) begin errors++; $display("FAIL rst_last got %0d exp 0", last_pkt_words); end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL rst_pkt_cnt got %0d exp 0", pkt_cnt); end
        checks++; if (fmt_err !== 1'b0) begin errors++; $display("FAIL rst_fmt_err got %b exp 0", fmt_err); end
        reset = 1'b1;
    endtask

    task automatic test_latency();
        logic [71:0] exp[3];
        logic [6:0]  rdv, wrv;
        exp[0] = {8'hFF, 64'hA000_0000_0000_0001};
        exp[1] = {8'h00, 64'hA000_0000_0000_0002};
        exp[2] = {8'h04, 64'hA000_0000_0000_0003};
        clr_mon();
        for (int i = 0; i < 3; i++) push(exp[i][71:64], exp[i][63:0]);
        drain_en = 1'b1; bus.out_rdy = 1'b1;
        repeat (7) tick();
        for (int i = 0; i < 7; i++) begin rdv[i] = rd_log[i]; wrv[i] = wr_log[i]; end
        checks++; if (rdv !== 7'b0000111) begin errors++; $display("FAIL lat_rd_pattern got %b exp 0000111", rdv); end
        checks++; if (wrv !== 7'b0011100) begin errors++; $display("FAIL lat_wr_pattern got %b exp 0011100", wrv); end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL lat_count got %0d exp 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL lat_word%0d got %h exp %h", i, got[i], exp[i]); end
        end
        checks++; if (got_eop.size() == 3 && {got_eop[0], got_eop[1], got_eop[2]} !== 3'b001) begin
            errors++; $display("FAIL lat_eop got %b%b%b exp 001", got_eop[0], got_eop[1], got_eop[2]); end
        checks++; if (last_pkt_words !== 4'd3) begin errors++; $display("FAIL lat_last got %0d exp 3", last_pkt_words); end
        checks++; if (pkt_cnt !== 4'd1) begin errors++; $display("FAIL lat_pkt_cnt got %0d exp 1", pkt_cnt); end
    endtask

    task automatic test_backpressure_packet();
        logic [71:0] exp[5];
        logic [7:0]  cv[5];
        cv[0] = 8'hFF; cv[1] = 8'h00; cv[2] = 8'h00; cv[3] = 8'h00; cv[4] = 8'h04;
        for (int i = 0; i < 5; i++) exp[i] = {cv[i], 64'hB000_0000_0000_0010 + 64'(i)};
        clr_mon();
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) push(exp[i][71:64], exp[i][63:0]);
        repeat (6) tick();
        checks++; if (n_rd !== 2) begin errors++; $display("FAIL bp_reads got %0d exp 2", n_rd); end
        checks++; if (rd_log[5] !== 1'b0) begin errors++; $display("FAIL bp_rd_held got %b exp 0", rd_log[5]); end
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL bp_no_out got %0d exp 0", got.size()); end
        bus.out_rdy = 1'b1;
        clr_mon();
        repeat (8) tick();
        checks++; if (got.size() !== 5) begin errors++; $display("FAIL bp_count got %0d exp 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_word%0d got %h exp %h", i, got[i], exp[i]); end
            checks++; if (got_eop[i] !== (i == 4)) begin errors++; $display("FAIL bp_eop%0d got %b exp %b", i, got_eop[i], i == 4); end
        end
        checks++; if (last_pkt_words !== 4'd5) begin errors++; $display("FAIL pkt_last got %0d exp 5", last_pkt_words); end
        checks++; if (pkt_cnt !== 4'd2) begin errors++; $display("FAIL pkt_cnt got %0d exp 2", pkt_cnt); end
        checks++; if (fmt_err !== 1'b0) begin errors++; $display("FAIL pkt_fmt_err got %b exp 0", fmt_err); end
    endtask

    task automatic test_fmt_err();
        reset = 1'b0; tick(); reset = 1'b1;
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL fmt_rst_cnt got %0d exp 0", pkt_cnt); end
        clr_mon();
        push(8'h00, 64'hC1); push(8'h00, 64'hC2); push(8'h04, 64'hC3);
        drain_en = 1'b1; bus.out_rdy = 1'b1;
        repeat (7) tick();
        checks++; if (fmt_err !== 1'b1) begin errors++; $display("FAIL fmt_set got %b exp 1", fmt_err); end
        checks++; if (last_pkt_words !== 4'd3) begin errors++; $display("FAIL fmt_last got %0d exp 3", last_pkt_words); end
        checks++; if (pkt_cnt !== 4'd1) begin errors++; $display("FAIL fmt_pkt_cnt got %0d exp 1", pkt_cnt); end
        push(8'hFF, 64'hC4); push(8'h00, 64'hC5); push(8'h04, 64'hC6);
        repeat (7) tick();
        checks++; if (fmt_err !== 1'b1) begin errors++; $display("FAIL fmt_sticky got %b exp 1", fmt_err); end
        checks++; if (pkt_cnt !== 4'd2) begin errors++; $display("FAIL fmt_pkt_cnt2 got %0d exp 2", pkt_cnt); end
        reset = 1'b0; tick(); reset = 1'b1;
        checks++; if (fmt_err !== 1'b0) begin errors++; $display("FAIL fmt_clear got %b exp 0", fmt_err); end
    endtask

    task automatic test_drain_drop();
        logic [71:0] exp[4];
        exp[0] = {8'hFF, 64'hD1}; exp[1] = {8'h00, 64'hD2};
        exp[2] = {8'h00, 64'hD3}; exp[3] = {8'h04, 64'hD4};
        clr_mon();
        for (int i = 0; i < 4; i++) push(exp[i][71:64], exp[i][63:0]);
        drain_en = 1'b1; bus.out_rdy = 1'b1;
        tick();
        drain_en = 1'b0;
        repeat (6) tick();
        checks++; if (rd_log[0] !== 1'b1) begin errors++; $display("FAIL dd_first_rd got %b exp 1", rd_log[0]); end
        checks++; if (n_rd !== 1) begin errors++; $display("FAIL dd_reads got %0d exp 1", n_rd); end
        checks++; if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL dd_fifo_nonempty got %b exp 0", bus.fifo_empty); end
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL dd_inflight_out got %0d exp 1", got.size()); end
        drain_en = 1'b1;
        repeat (8) tick();
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL dd_count got %0d exp 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL dd_word%0d got %h exp %h", i, got[i], exp[i]); end
        end
        checks++; if (last_pkt_words !== 4'd4) begin errors++; $display("FAIL dd_last got %0d exp 4", last_pkt_words); end
        checks++; if (pkt_cnt !== 4'd1) begin errors++; $display("FAIL dd_pkt_cnt got %0d exp 1", pkt_cnt); end
    endtask

    task automatic test_reset_mid();
        clr_mon();
        bus.out_rdy = 1'b0; drain_en = 1'b1;
        push(8'hFF, 64'hE1); push(8'h00, 64'hE2);
        repeat (4) tick();
        checks++; if (n_rd !== 2) begin errors++; $display("FAIL rm_reads got %0d exp 2", n_rd); end
        reset = 1'b0; tick(); reset = 1'b1;
        bus.out_rdy = 1'b1;
        tick();
        checks++; if (wr_log[wr_log.size()-1] !== 1'b0) begin errors++; $display("FAIL rm_out_wr got 1 exp 0"); end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL rm_pkt_cnt got %0d exp 0", pkt_cnt); end
        clr_mon();
        push(8'hFF, 64'hE3); push(8'h00, 64'hE4); push(8'h00, 64'hE5); push(8'h04, 64'hE6);
        repeat (8) tick();
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL rm_count got %0d exp 4", got.size()); end
        checks++; if (got.size() > 0 && got[0] !== {8'hFF, 64'hE3}) begin errors++; $display("FAIL rm_first got %h exp ff%h", got[0], 64'hE3); end
        checks++; if (last_pkt_words !== 4'd4) begin errors++; $display("FAIL rm_last got %0d exp 4", last_pkt_words); end
        checks++; if (pkt_cnt !== 4'd1) begin errors++; $display("FAIL rm_pkt_cnt2 got %0d exp 1", pkt_cnt); end
        checks++; if (fmt_err !== 1'b0) begin errors++; $display("FAIL rm_fmt_err got %b exp 0", fmt_err); end
    endtask

    task automatic test_pkt_wrap();
        int n_eop;
        clr_mon();
        for (int p = 0; p < 15; p++) begin
            push(8'hFF, 64'hF000 + 64'(p));
            push(8'h00, 64'hF100 + 64'(p));
            push(8'h08, 64'hF200 + 64'(p));
        end
        drain_en = 1'b1; bus.out_rdy = 1'b1;
        repeat (60) tick();
        n_eop = 0;
        foreach (got_eop[i]) if (got_eop[i]) n_eop++;
        checks++; if (got.size() !== 45) begin errors++; $display("FAIL wrap_count got %0d exp 45", got.size()); end
        checks++; if (n_eop !== 15) begin errors++; $display("FAIL wrap_eops got %0d exp 15", n_eop); end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL wrap_pkt_cnt got %0d exp 0", pkt_cnt); end
        checks++; if (last_pkt_words !== 4'd3) begin errors++; $display("FAIL wrap_last got %0d exp 3", last_pkt_words); end
    endtask

    initial begin
        reset = 1'b0; drain_en = 1'b0; bus.out_rdy = 1'b0;
        test_reset();
        test_latency();
        test_backpressure_packet();
        test_fmt_err();
        test_drain_drop();
        test_reset_mid();
        test_pkt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
